// File: rtl/quad_steer_n.sv
`default_nettype none
// ============================================================================
// quad_steer_n : per-channel quadrature steering generator, digital or analog
// Revision     : 1.0
// ============================================================================
module quad_steer_n #(
  parameter int CHANNELS   = 2,
  parameter int DIV_W      = 16,
  parameter int ACCEL_MAX  = 3,
  parameter int ACCEL_HOLD = 8,
  parameter int DEADZONE   = 8
) (
  input  logic                  CLK,
  input  logic                  reset,
  input  logic [DIV_W-1:0]      clkdiv,
  input  logic                  mode,
  input  logic                  accel_en,
  input  logic [CHANNELS-1:0]   right,
  input  logic [CHANNELS-1:0]   left,
  input  logic [8*CHANNELS-1:0] analog,
  output logic [CHANNELS-1:0]   steerA,
  output logic [CHANNELS-1:0]   steerB,
  output logic [CHANNELS-1:0]   moving,
  output logic [CHANNELS-1:0]   dir
);

  localparam int LVL_W = (ACCEL_MAX > 0) ? $clog2(ACCEL_MAX + 1) : 1;
  localparam int STP_W = (ACCEL_HOLD > 1) ? $clog2(ACCEL_HOLD) : 1;
  localparam logic [LVL_W-1:0] LVL_MAX  = LVL_W'(ACCEL_MAX);
  localparam logic [STP_W-1:0] STP_LAST = STP_W'(ACCEL_HOLD - 1);
  localparam logic [7:0]       DZ       = 8'(DEADZONE);

  // Step period in cycles, never below 1.
  function automatic logic [DIV_W-1:0] f_period(input logic [DIV_W-1:0] div,
                                                input logic amode,
                                                input logic acc,
                                                input logic [7:0] mag,
                                                input logic [LVL_W-1:0] lvl);
    logic [DIV_W+6:0] prod;
    logic [DIV_W-1:0] p;
    prod = (DIV_W+7)'(div) * (DIV_W+7)'(8'd128 - mag);
    if (amode)    p = DIV_W'(prod >> 7);
    else if (acc) p = div >> lvl;
    else          p = div;
    if (p == '0) p = DIV_W'(1);
    return p;
  endfunction

  logic mode_q, mode_d, mode_chg;
  assign mode_d   = mode;
  assign mode_chg = (mode != mode_q);

  always_ff @(posedge CLK) begin
    if (reset) mode_q <= 1'b0;
    else       mode_q <= mode_d;
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    logic [7:0]       a_raw, mag;
    logic             req, rdir, step;
    logic [1:0]       phase_q, phase_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic [STP_W-1:0] steps_q, steps_d;
    logic             moving_q, moving_d, dir_q, dir_d;

    assign a_raw = analog[8*i +: 8];

    always_comb begin
      mag = a_raw;
      if (a_raw[7]) mag = (a_raw == 8'h80) ? 8'd127 : (~a_raw + 8'd1);
      if (mode) begin
        req  = (mag > DZ);
        rdir = ~a_raw[7];
      end else begin
        req  = right[i] ^ left[i];
        rdir = right[i];
      end
    end

    always_comb begin
      phase_d  = phase_q;
      cnt_d    = cnt_q;
      level_d  = level_q;
      steps_d  = steps_q;
      moving_d = req;
      dir_d    = req ? rdir : dir_q;
      step     = 1'b0;
      if (!req || (moving_q && (rdir != dir_q))) begin
        level_d = '0;
        steps_d = '0;
        cnt_d   = f_period(clkdiv, mode, accel_en, mag, '0) - DIV_W'(1);
      end else begin
        if (mode_chg) begin
          level_d = '0;
          steps_d = '0;
        end
        // A fresh request counts its own edge as the first cycle of the period.
        if (!moving_q) begin
          if (f_period(clkdiv, mode, accel_en, mag, level_d) == DIV_W'(1)) step = 1'b1;
          else cnt_d = f_period(clkdiv, mode, accel_en, mag, level_d) - DIV_W'(2);
        end else if (cnt_q == '0) begin
          step = 1'b1;
        end else begin
          cnt_d = cnt_q - DIV_W'(1);
        end
        if (step) begin
          phase_d = rdir ? {phase_q[0], ~phase_q[1]} : {~phase_q[0], phase_q[1]};
          if (!mode && accel_en) begin
            if (steps_d == STP_LAST) begin
              steps_d = '0;
              if (level_d != LVL_MAX) level_d = level_d + LVL_W'(1);
            end else begin
              steps_d = steps_d + STP_W'(1);
            end
          end
          cnt_d = f_period(clkdiv, mode, accel_en, mag, level_d) - DIV_W'(1);
        end
      end
    end

    always_ff @(posedge CLK) begin
      if (reset) begin
        phase_q  <= 2'b00;
        cnt_q    <= '0;
        level_q  <= '0;
        steps_q  <= '0;
        moving_q <= 1'b0;
        dir_q    <= 1'b0;
      end else begin
        phase_q  <= phase_d;
        cnt_q    <= cnt_d;
        level_q  <= level_d;
        steps_q  <= steps_d;
        moving_q <= moving_d;
        dir_q    <= dir_d;
      end
    end

    assign steerA[i] = phase_q[1];
    assign steerB[i] = phase_q[0];
    assign moving[i] = moving_q;
    assign dir[i]    = dir_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_quad_steer_n.sv
`default_nettype none
// ============================================================================
// tb_quad_steer_n : randomized and directed bench with a due-time step model
// Revision        : 1.0
// ============================================================================
module tb_quad_steer_n;
  localparam int CH = 2, DW = 16, AMAX = 3, AHOLD = 8, DZN = 8;

  logic            CLK = 1'b0;
  logic            reset;
  logic [DW-1:0]   clkdiv;
  logic            mode, accel_en;
  logic [CH-1:0]   right, left;
  logic [8*CH-1:0] analog;
  logic [CH-1:0]   steerA, steerB, moving, dir;

  always #5 CLK = ~CLK;

  quad_steer_n #(.CHANNELS(CH), .DIV_W(DW), .ACCEL_MAX(AMAX), .ACCEL_HOLD(AHOLD),
                 .DEADZONE(DZN)) dut (
    .CLK(CLK), .reset(reset), .clkdiv(clkdiv), .mode(mode), .accel_en(accel_en),
    .right(right), .left(left), .analog(analog),
    .steerA(steerA), .steerB(steerB), .moving(moving), .dir(dir));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Model: phase as a position 0..3 around the cycle, next step as an absolute edge number.
  int  m_ph[CH], m_lvl[CH], m_stp[CH], m_due[CH];
  bit  m_mov[CH], m_dir[CH];
  bit  m_pmode;
  int  cyc = 0;

  function automatic logic [1:0] gray(input int i);
    case (i)
      0:       return 2'b00;
      1:       return 2'b01;
      2:       return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  function automatic int mag_of(input int c);
    logic signed [7:0] b;
    int a;
    b = analog[8*c +: 8];
    a = b;
    if (a < 0) a = -a;
    if (a > 127) a = 127;
    return a;
  endfunction

  function automatic longint period(input int c, input int lvl);
    longint p;
    if (mode)          p = (longint'(clkdiv) * (128 - mag_of(c))) / 128;
    else if (accel_en) p = longint'(clkdiv) / (longint'(1) << lvl);
    else               p = longint'(clkdiv);
    if (p < 1) p = 1;
    return p;
  endfunction

  task automatic model_edge();
    bit req, rd;
    cyc++;
    if (reset) begin
      for (int c = 0; c < CH; c++) begin
        m_ph[c] = 0; m_lvl[c] = 0; m_stp[c] = 0; m_due[c] = 0;
        m_mov[c] = 0; m_dir[c] = 0;
      end
      m_pmode = 0;
      return;
    end
    for (int c = 0; c < CH; c++) begin
      if (mode) begin
        req = (mag_of(c) > DZN);
        rd  = !analog[8*c+7];
      end else begin
        req = (right[c] != left[c]);
        rd  = right[c];
      end
      if (!req) begin
        m_lvl[c] = 0; m_stp[c] = 0; m_mov[c] = 0;
      end else if (m_mov[c] && rd != m_dir[c]) begin
        m_lvl[c] = 0; m_stp[c] = 0;
        m_due[c] = cyc + int'(period(c, 0));
        m_dir[c] = rd;
      end else begin
        if (mode != m_pmode) begin m_lvl[c] = 0; m_stp[c] = 0; end
        if (!m_mov[c]) m_due[c] = cyc + int'(period(c, m_lvl[c])) - 1;
        if (cyc == m_due[c]) begin
          m_ph[c] = rd ? (m_ph[c] + 1) % 4 : (m_ph[c] + 3) % 4;
          if (!mode && accel_en) begin
            m_stp[c]++;
            if (m_stp[c] == AHOLD) begin
              m_stp[c] = 0;
              if (m_lvl[c] < AMAX) m_lvl[c]++;
            end
          end
          m_due[c] = cyc + int'(period(c, m_lvl[c]));
        end
        m_mov[c] = 1;
        m_dir[c] = rd;
      end
    end
    m_pmode = mode;
  endtask

  task automatic tick();
    @(posedge CLK);
    model_edge();
    #1;
    for (int c = 0; c < CH; c++)
      check($sformatf("ch%0d edge%0d {A,B,mov,dir}", c, cyc),
            {28'd0, steerA[c], steerB[c], moving[c], dir[c]},
            {28'd0, gray(m_ph[c]), m_mov[c], m_dir[c]});
  endtask

  task automatic set_idle();
    right = '0; left = '0; analog = '0; mode = 1'b0; accel_en = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; tick(); tick(); reset = 1'b0;
  endtask

  logic [1:0] e036 [4];
  logic [1:0] ph, prev;
  int nsteps, last, lat, exp_iv;

  initial begin
    e036 = '{2'b01, 2'b11, 2'b10, 2'b00};
    set_idle();
    clkdiv = 16'd4;
    reset  = 1'b1;
    tick(); tick();
    check("reset outputs", {24'd0, steerA, steerB, moving, dir}, 32'd0);

    // Digital right on channel 0, period 4.
    reset = 1'b0; right = 2'b01;
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k % 4 == 0) begin
        check($sformatf("r036 ch0 phase at %0d", k), {30'd0, steerA[0], steerB[0]}, {30'd0, e036[k/4-1]});
        check($sformatf("r036 ch1 phase at %0d", k), {30'd0, steerA[1], steerB[1]}, 32'd0);
      end
    end

    // Acceleration ladder.
    set_idle(); do_reset();
    clkdiv = 16'd16; accel_en = 1'b1; left = 2'b01;
    nsteps = 0; last = 0; prev = {steerA[0], steerB[0]};
    for (int t = 1; t <= 600 && nsteps < 28; t++) begin
      tick();
      ph = {steerA[0], steerB[0]};
      if (ph != prev) begin
        nsteps++;
        exp_iv = (nsteps <= 8) ? 16 : (nsteps <= 16) ? 8 : (nsteps <= 24) ? 4 : 2;
        check($sformatf("r037 step%0d interval", nsteps), t - last, exp_iv);
        last = t; prev = ph;
      end
    end
    check("r037 step count", nsteps, 28);

    // Both buttons, then release left.
    set_idle(); do_reset();
    clkdiv = 16'd5; right = 2'b01; left = 2'b01;
    for (int k = 0; k < 20; k++) tick();
    check("r038 moving while both", {31'd0, moving[0]}, 32'd0);
    check("r038 phase frozen", {30'd0, steerA[0], steerB[0]}, 32'd0);
    left = 2'b00; lat = 0;
    for (int t = 1; t <= 50 && lat == 0; t++) begin
      tick();
      if ({steerA[0], steerB[0]} != 2'b00) lat = t;
    end
    check("r038 first step latency", lat, 5);

    // Analog mode.
    set_idle(); do_reset();
    mode = 1'b1; clkdiv = 16'd256; analog = {8'h80, 8'h40};
    for (int k = 0; k < 300; k++) tick();
    analog = {8'h09, 8'h08};
    for (int k = 0; k < 20; k++) tick();
    check("r039 deadzone idle", {31'd0, moving[0]}, 32'd0);

    // Reversal mid-count with acceleration.
    set_idle(); do_reset();
    clkdiv = 16'd6; accel_en = 1'b1; right = 2'b01;
    for (int k = 0; k < 40; k++) tick();
    right = 2'b00; left = 2'b01;
    for (int k = 0; k < 30; k++) tick();

    // Reset pulse mid-count with clkdiv 0.
    set_idle(); clkdiv = 16'd0; right = 2'b11;
    for (int k = 0; k < 5; k++) tick();
    reset = 1'b1; tick();
    check("r041 outputs in reset", {24'd0, steerA, steerB, moving, dir}, 32'd0);
    reset = 1'b0;
    for (int k = 0; k < 10; k++) tick();

    // Randomized traffic.
    set_idle(); do_reset();
    for (int k = 0; k < 4000; k++) begin
      case ($urandom_range(0, 15))
        0: right    = CH'($urandom);
        1: left     = CH'($urandom);
        2: analog   = (8*CH)'($urandom);
        3: clkdiv   = DW'($urandom_range(0, 40));
        4: if ($urandom_range(0, 3) == 0) mode = ~mode;
        5: accel_en = 1'($urandom);
        default: ;
      endcase
      reset = ($urandom_range(0, 499) == 0);
      tick();
    end
    reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/quad_steer_n.md
QUAD_STEER_N -- requirements
Module: quad_steer_n

Interface
REQ-001 SHALL provide parameter CHANNELS, default 2: number of independent steering channels.
REQ-002 SHALL provide parameter DIV_W, default 16: width of the step-period divider.
REQ-003 SHALL provide parameter ACCEL_MAX, default 3: maximum acceleration level; period is halved once per level.
REQ-004 SHALL provide parameter ACCEL_HOLD, default 8: quadrature steps taken at one level before moving up a level.
REQ-005 SHALL provide parameter DEADZONE, default 8: analog magnitudes at or below this value produce no motion.
REQ-006 SHALL provide port CLK, input, 1 bit: the single system clock.
REQ-007 SHALL provide port reset, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL provide port clkdiv, input, DIV_W bits: base step period in CLK cycles; 0 is treated as 1.
REQ-009 SHALL provide port mode, input, 1 bit: 0 = digital left/right, 1 = analog.
REQ-010 SHALL provide port accel_en, input, 1 bit: enables acceleration in digital mode.
REQ-011 SHALL provide port right, input, CHANNELS bits: per-channel digital right request.
REQ-012 SHALL provide port left, input, CHANNELS bits: per-channel digital left request.
REQ-013 SHALL provide port analog, input, 8*CHANNELS bits: per-channel signed two's-complement stick value; positive means right.
REQ-014 SHALL provide port steerA, output, CHANNELS bits: quadrature phase A.
REQ-015 SHALL provide port steerB, output, CHANNELS bits: quadrature phase B.
REQ-016 SHALL provide port moving, output, CHANNELS bits: channel currently requesting motion.
REQ-017 SHALL provide port dir, output, CHANNELS bits: last commanded direction; 1 = right.

Function
REQ-018 SHALL make every channel fully independent; shared inputs are clkdiv, mode and accel_en only.
REQ-019 SHALL hold per channel a 2-bit phase {A,B}, a DIV_W-bit down-counter, and an acceleration level of 0..ACCEL_MAX with a step count of 0..ACCEL_HOLD-1.
REQ-020 SHALL step the phase right as 00->01->11->10->00 and left in the reverse order, one transition per step.
REQ-021 SHALL derive the digital request as: right only -> right; left only -> left; both or neither -> no motion.
REQ-022 SHALL take magnitude m = |analog| in analog mode, with -128 clamped to 127, and request motion only when m > DEADZONE, with direction given by the sign.
REQ-023 SHALL compute the digital period as max(1, clkdiv >> level) when accel_en=1, and as clkdiv otherwise.
REQ-024 SHALL compute the analog period as max(1, (clkdiv*(128-m))>>7), using a full-width product; acceleration is ignored in analog mode.
REQ-025 SHALL load the counter with period-1 on every idle cycle (no request); while a request is present it SHALL decrement, and at 0 it SHALL apply one step and reload period-1.
REQ-026 SHALL therefore produce the first step exactly `period` cycles after the request appears, and one step every `period` cycles thereafter.
REQ-027 SHALL, on a direction reversal with no idle cycle between, reload the counter, hold the phase, and reset the acceleration level and step count to 0.
REQ-028 SHALL, on each step with accel_en=1, increment the step count; on reaching ACCEL_HOLD it SHALL clear the step count and increment the level, saturating at ACCEL_MAX.
REQ-029 SHALL clear the level and step count on any idle cycle, on a direction change, and on any change of mode.
REQ-030 SHALL sample clkdiv changes only at counter reload; a count in progress is not affected.
REQ-031 SHALL retain the phase while idle; idle outputs are static.
REQ-032 SHALL register all outputs, with moving and dir updated one cycle after the request changes.

Reset
REQ-033 SHALL, while reset=1, force phase=00, counter=0, level=0, step count=0, and steerA=steerB=moving=dir=0 on all channels.
REQ-034 SHALL, on reset asserted mid-count, apply the reset values at the next CLK edge and discard any partial period.
REQ-035 SHALL treat the first cycle after reset release as an idle cycle when no request is present.

Verification
REQ-036 SHALL cover: clkdiv=4, mode=0, right[0]=1 held -> channel 0 {A,B} goes 01,11,10,00 at cycles 4,8,12,16; channel 1 stays 00.
REQ-037 SHALL cover: clkdiv=16, accel_en=1, ACCEL_HOLD=8, left held -> 8 steps at period 16, 8 at 8, 8 at 4, then period 2 sustained.
REQ-038 SHALL cover: right and left both asserted -> moving=0 and phase frozen; release left -> first right step exactly clkdiv cycles later.
REQ-039 SHALL cover: mode=1, clkdiv=256, analog=+64 -> period 128, stepping right; analog=-128 -> period 2, stepping left; analog=+8 -> no motion.
REQ-040 SHALL cover: right held, reversed to left mid-count -> phase held, next step in reverse order a full period later, level back to 0.
REQ-041 SHALL cover: reset pulsed for one cycle mid-count with clkdiv=0 -> all outputs 0; afterwards a held request steps every cycle.
